// File: rtl/bp_fe_mock_be_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bp_fe_mock_be_if                                              |
// | Brief    : FE queue / FE command handshake bundle for bp_fe_mock_be.     |
// |            master = mock back end side, slave = FE / FIFO side.          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface bp_fe_mock_be_if #(
    parameter int vaddr_width_p               = 39,
    parameter int paddr_width_p               = 40,
    parameter int asid_width_p                = 10,
    parameter int branch_metadata_fwd_width_p = 36
) ();
    // queue packet: {msg_type(1: 0=fetch,1=exception), pc, instr[31:0], branch_metadata}
    localparam int fe_queue_width_lp = 1 + vaddr_width_p + 32 + branch_metadata_fwd_width_p;
    // command: {opcode[2:0], vaddr, paddr, asid, branch_metadata}
    localparam int fe_cmd_width_lp   = 3 + vaddr_width_p + paddr_width_p + asid_width_p
                                     + branch_metadata_fwd_width_p;

    logic [fe_queue_width_lp-1:0] fe_queue_i;
    logic                         fe_queue_v_i;
    logic                         fe_queue_yumi_o;
    logic                         fe_queue_clr_o;
    logic                         fe_queue_dequeue_o;
    logic                         fe_queue_rollback_o;
    logic [fe_cmd_width_lp-1:0]   fe_cmd_o;
    logic                         fe_cmd_v_o;
    logic                         fe_cmd_rdy_i;

    modport master (
        input  fe_queue_i, fe_queue_v_i, fe_cmd_rdy_i,
        output fe_queue_yumi_o, fe_queue_clr_o, fe_queue_dequeue_o,
               fe_queue_rollback_o, fe_cmd_o, fe_cmd_v_o
    );

    modport slave (
        output fe_queue_i, fe_queue_v_i, fe_cmd_rdy_i,
        input  fe_queue_yumi_o, fe_queue_clr_o, fe_queue_dequeue_o,
               fe_queue_rollback_o, fe_cmd_o, fe_cmd_v_o
    );
endinterface
`default_nettype wire

// File: rtl/bp_fe_mock_be.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bp_fe_mock_be                                                 |
// | Brief    : Mock back end: consumes FE queue, checks sequential PCs,      |
// |            issues periodic PC redirects, flags done / error.             |
// |            Optional PC checking: define BP_FE_MOCK_BE_CHECK_EN.          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module bp_fe_mock_be #(
    parameter int          vaddr_width_p               = 39,
    parameter int          paddr_width_p               = 40,
    parameter int          asid_width_p                = 10,
    parameter int          branch_metadata_fwd_width_p = 36,
    parameter logic [63:0] boot_pc_p                   = 64'h80000124,
    parameter int          redirect_every_p            = 16,
    parameter logic [63:0] redirect_offset_p           = 64'h40,
    parameter int          max_instr_p                 = 256,
    parameter int          mismatch_limit_p            = 8
) (
    input  wire logic        clk_i,
    input  wire logic        reset_n_i,
    bp_fe_mock_be_if.master  fe_if,
    output logic [31:0]      instr_cnt_o,
    output logic             done_o,
    output logic             error_o
);

    localparam int fe_queue_width_lp = 1 + vaddr_width_p + 32 + branch_metadata_fwd_width_p;
    localparam int fe_cmd_width_lp   = 3 + vaddr_width_p + paddr_width_p + asid_width_p
                                     + branch_metadata_fwd_width_p;
    localparam int cmd_pad_lp        = paddr_width_p + asid_width_p + branch_metadata_fwd_width_p;

    localparam logic [2:0]               c_op_pc_redirection = 3'd1;
    localparam logic [vaddr_width_p-1:0] c_boot_pc           = boot_pc_p[vaddr_width_p-1:0];
    localparam logic [vaddr_width_p-1:0] c_redir_off         = redirect_offset_p[vaddr_width_p-1:0];
    localparam logic [vaddr_width_p-1:0] c_pc_step           = vaddr_width_p'(4);
    localparam logic [32:0]              c_max_instr         = 33'(max_instr_p);
    localparam logic [31:0]              c_redir_every       = 32'(redirect_every_p);
    localparam logic [31:0]              c_mismatch_limit    = 32'(mismatch_limit_p);

    typedef enum logic [2:0] {
        eRun   = 3'd0,
        eCmd   = 3'd1,
        eFlush = 3'd2,
        eDone  = 3'd3,
        eError = 3'd4
    } state_e;

    state_e                     r_state,     w_state_nxt;
    logic [vaddr_width_p-1:0]   r_exp_pc,    w_exp_pc_nxt;
    logic [vaddr_width_p-1:0]   r_target,    w_target_nxt;
    logic [31:0]                r_instr_cnt, w_instr_cnt_nxt;
    logic [31:0]                r_redir_cnt, w_redir_cnt_nxt;
    logic                       r_done,      w_done_nxt;
    logic                       r_error,     w_error_nxt;
    logic [fe_cmd_width_lp-1:0] r_fe_cmd,    w_fe_cmd_nxt;

    logic                       w_yumi;
    logic                       w_dequeue;
    logic                       w_clr;
    logic                       w_cmd_v;

    logic                       w_is_exc;
    logic [vaddr_width_p-1:0]   w_pc;
    logic [vaddr_width_p-1:0]   w_acc_pc;
    logic [vaddr_width_p-1:0]   w_acc_pc_next;
    logic [vaddr_width_p-1:0]   w_redir_target;
    logic [31:0]                w_instr_cnt_inc;
    logic                       w_hit_max;
    logic                       w_hit_redir;
    logic                       w_pc_ok;
    logic                       w_unused;

    assign w_is_exc = fe_if.fe_queue_i[fe_queue_width_lp-1];
    assign w_pc     = fe_if.fe_queue_i[fe_queue_width_lp-2 -: vaddr_width_p];

`ifdef BP_FE_MOCK_BE_CHECK_EN
    logic [31:0] r_mismatch_cnt, w_mismatch_nxt;
    logic        w_mismatch_hit;

    assign w_pc_ok        = (w_pc == r_exp_pc);
    assign w_acc_pc       = r_exp_pc;
    assign w_mismatch_hit = ((r_mismatch_cnt + 32'd1) == c_mismatch_limit);
    assign w_unused       = ^fe_if.fe_queue_i[32+branch_metadata_fwd_width_p-1:0];
`else
    // Without checking, the packet's own PC becomes the reference.
    assign w_pc_ok  = 1'b1;
    assign w_acc_pc = w_pc;
    assign w_unused = ^{fe_if.fe_queue_i[32+branch_metadata_fwd_width_p-1:0], c_mismatch_limit};
`endif

    assign w_acc_pc_next   = w_acc_pc + c_pc_step;
    assign w_redir_target  = w_acc_pc_next + c_redir_off;
    assign w_instr_cnt_inc = (&r_instr_cnt) ? r_instr_cnt : (r_instr_cnt + 32'd1);
    assign w_hit_max       = (({1'b0, r_instr_cnt} + 33'd1) == c_max_instr);
    assign w_hit_redir     = ((r_redir_cnt + 32'd1) == c_redir_every);

    always_comb begin
        w_state_nxt     = r_state;
        w_exp_pc_nxt    = r_exp_pc;
        w_target_nxt    = r_target;
        w_instr_cnt_nxt = r_instr_cnt;
        w_redir_cnt_nxt = r_redir_cnt;
        w_done_nxt      = r_done;
        w_error_nxt     = r_error;
        w_fe_cmd_nxt    = r_fe_cmd;
`ifdef BP_FE_MOCK_BE_CHECK_EN
        w_mismatch_nxt  = r_mismatch_cnt;
`endif
        w_yumi          = 1'b0;
        w_dequeue       = 1'b0;
        w_clr           = 1'b0;
        w_cmd_v         = 1'b0;

        case (r_state)
            eRun: begin
                w_yumi = fe_if.fe_queue_v_i;
                if (fe_if.fe_queue_v_i) begin
                    if (w_is_exc) begin
                        w_state_nxt = eError;
                        w_error_nxt = 1'b1;
                    end else if (w_pc_ok) begin
                        w_dequeue       = 1'b1;
                        w_instr_cnt_nxt = w_instr_cnt_inc;
                        w_exp_pc_nxt    = w_acc_pc_next;
`ifdef BP_FE_MOCK_BE_CHECK_EN
                        w_mismatch_nxt  = '0;
`endif
                        // Completion wins over a redirect due on the same accept.
                        if (w_hit_max) begin
                            w_state_nxt = eDone;
                            w_done_nxt  = 1'b1;
                        end else if (w_hit_redir) begin
                            w_state_nxt     = eCmd;
                            w_target_nxt    = w_redir_target;
                            w_redir_cnt_nxt = '0;
                            w_fe_cmd_nxt    = {c_op_pc_redirection, w_redir_target,
                                               {cmd_pad_lp{1'b0}}};
                        end else begin
                            w_redir_cnt_nxt = r_redir_cnt + 32'd1;
                        end
                    end
`ifdef BP_FE_MOCK_BE_CHECK_EN
                    else begin
                        w_mismatch_nxt = r_mismatch_cnt + 32'd1;
                        if (w_mismatch_hit) begin
                            w_state_nxt = eError;
                            w_error_nxt = 1'b1;
                        end
                    end
`endif
                end
            end
            eCmd: begin
                w_cmd_v = fe_if.fe_cmd_rdy_i;
                if (fe_if.fe_cmd_rdy_i) begin
                    w_state_nxt = eFlush;
                end
            end
            eFlush: begin
                w_clr        = 1'b1;
                w_exp_pc_nxt = r_target;
`ifdef BP_FE_MOCK_BE_CHECK_EN
                w_mismatch_nxt = '0;
`endif
                w_state_nxt  = eRun;
            end
            eDone: begin
                w_done_nxt = 1'b1;
            end
            eError: begin
                w_error_nxt = 1'b1;
            end
            default: begin
                // Unreachable encodings park in the error state.
                w_state_nxt = eError;
                w_error_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state        <= eRun;
            r_exp_pc       <= c_boot_pc;
            r_target       <= '0;
            r_instr_cnt    <= '0;
            r_redir_cnt    <= '0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
            r_fe_cmd       <= '0;
`ifdef BP_FE_MOCK_BE_CHECK_EN
            r_mismatch_cnt <= '0;
`endif
        end else begin
            r_state        <= w_state_nxt;
            r_exp_pc       <= w_exp_pc_nxt;
            r_target       <= w_target_nxt;
            r_instr_cnt    <= w_instr_cnt_nxt;
            r_redir_cnt    <= w_redir_cnt_nxt;
            r_done         <= w_done_nxt;
            r_error        <= w_error_nxt;
            r_fe_cmd       <= w_fe_cmd_nxt;
`ifdef BP_FE_MOCK_BE_CHECK_EN
            r_mismatch_cnt <= w_mismatch_nxt;
`endif
        end
    end

    assign fe_if.fe_queue_yumi_o     = w_yumi;
    assign fe_if.fe_queue_dequeue_o  = w_dequeue;
    assign fe_if.fe_queue_clr_o      = w_clr;
    assign fe_if.fe_queue_rollback_o = 1'b0;
    assign fe_if.fe_cmd_v_o          = w_cmd_v;
    assign fe_if.fe_cmd_o            = r_fe_cmd;

    assign instr_cnt_o = r_instr_cnt;
    assign done_o      = r_done;
    assign error_o     = r_error;

endmodule
`default_nettype wire

// File: tb/tb_bp_fe_mock_be.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_bp_fe_mock_be                                              |
// | Brief    : Directed table-driven bench for bp_fe_mock_be.                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_bp_fe_mock_be;
    localparam int VA = 39;
    localparam int PA = 40;
    localparam int AS = 10;
    localparam int BM = 36;
    localparam int QW = 1 + VA + 32 + BM;
    localparam int CW = 3 + VA + PA + AS + BM;

    typedef struct {
        logic          v;
        logic          exc;
        logic [VA-1:0] pc;
        logic          rdy;
        logic          e_yumi;
        logic          e_deq;
        logic          e_clr;
        logic          e_cmdv;
        logic [VA-1:0] e_vaddr;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int yc, dc, cc;

    logic [31:0] a_cnt, b_cnt;
    logic        a_done, a_err, b_done, b_err;

    bp_fe_mock_be_if #(.vaddr_width_p(VA), .paddr_width_p(PA), .asid_width_p(AS),
                       .branch_metadata_fwd_width_p(BM)) a_if ();
    bp_fe_mock_be_if #(.vaddr_width_p(VA), .paddr_width_p(PA), .asid_width_p(AS),
                       .branch_metadata_fwd_width_p(BM)) b_if ();

    bp_fe_mock_be #(
        .vaddr_width_p(VA), .paddr_width_p(PA), .asid_width_p(AS),
        .branch_metadata_fwd_width_p(BM), .redirect_every_p(4),
        .max_instr_p(64), .mismatch_limit_p(8)
    ) dut_a (
        .clk_i(clk), .reset_n_i(rst_n), .fe_if(a_if),
        .instr_cnt_o(a_cnt), .done_o(a_done), .error_o(a_err)
    );

    bp_fe_mock_be #(
        .vaddr_width_p(VA), .paddr_width_p(PA), .asid_width_p(AS),
        .branch_metadata_fwd_width_p(BM), .redirect_every_p(16),
        .max_instr_p(16), .mismatch_limit_p(8)
    ) dut_b (
        .clk_i(clk), .reset_n_i(rst_n), .fe_if(b_if),
        .instr_cnt_o(b_cnt), .done_o(b_done), .error_o(b_err)
    );

    function automatic logic [QW-1:0] mk_pkt(input logic exc, input logic [VA-1:0] pc);
        return {exc, pc, 32'h00000013, {BM{1'b0}}};
    endfunction

    function automatic logic [CW-1:0] mk_cmd(input logic [VA-1:0] vaddr);
        return {3'd1, vaddr, {(PA+AS+BM){1'b0}}};
    endfunction

    function automatic vec_t mkv(input logic v, input logic exc, input logic [VA-1:0] pc,
                                 input logic rdy, input logic ey, input logic ed,
                                 input logic ec, input logic ecv, input logic [VA-1:0] ea);
        vec_t r;
        r.v = v; r.exc = exc; r.pc = pc; r.rdy = rdy;
        r.e_yumi = ey; r.e_deq = ed; r.e_clr = ec; r.e_cmdv = ecv; r.e_vaddr = ea;
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_a(input logic v, input logic exc, input logic [VA-1:0] pc, input logic rdy);
        @(negedge clk);
        a_if.fe_queue_v_i = v;
        a_if.fe_queue_i   = mk_pkt(exc, pc);
        a_if.fe_cmd_rdy_i = rdy;
        #1;
    endtask

    task automatic apply_b(input logic v, input logic [VA-1:0] pc);
        @(negedge clk);
        b_if.fe_queue_v_i = v;
        b_if.fe_queue_i   = mk_pkt(1'b0, pc);
        b_if.fe_cmd_rdy_i = 1'b1;
        #1;
    endtask

    vec_t tbl [13];

    initial begin
        // redirect_every=4: 4 accepts, 5 cycles rdy low, command, flush, resume at 0x..174
        tbl[0]  = mkv(1, 0, 39'h80000124, 1, 1, 1, 0, 0, 39'h0);
        tbl[1]  = mkv(1, 0, 39'h80000128, 1, 1, 1, 0, 0, 39'h0);
        tbl[2]  = mkv(1, 0, 39'h8000012c, 1, 1, 1, 0, 0, 39'h0);
        tbl[3]  = mkv(1, 0, 39'h80000130, 1, 1, 1, 0, 0, 39'h0);
        tbl[4]  = mkv(1, 0, 39'h80000134, 0, 0, 0, 0, 0, 39'h0);
        tbl[5]  = mkv(1, 0, 39'h80000134, 0, 0, 0, 0, 0, 39'h0);
        tbl[6]  = mkv(1, 0, 39'h80000134, 0, 0, 0, 0, 0, 39'h0);
        tbl[7]  = mkv(1, 0, 39'h80000134, 0, 0, 0, 0, 0, 39'h0);
        tbl[8]  = mkv(1, 0, 39'h80000134, 0, 0, 0, 0, 0, 39'h0);
        tbl[9]  = mkv(1, 0, 39'h80000134, 1, 0, 0, 0, 1, 39'h80000174);
        tbl[10] = mkv(1, 0, 39'h80000134, 1, 0, 0, 1, 0, 39'h0);
        tbl[11] = mkv(1, 0, 39'h80000174, 1, 1, 1, 0, 0, 39'h0);
        tbl[12] = mkv(1, 0, 39'h80000178, 1, 1, 1, 0, 0, 39'h0);

        a_if.fe_queue_v_i = 1'b0; a_if.fe_queue_i = '0; a_if.fe_cmd_rdy_i = 1'b1;
        b_if.fe_queue_v_i = 1'b0; b_if.fe_queue_i = '0; b_if.fe_cmd_rdy_i = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_yumi",     a_if.fe_queue_yumi_o,     0);
        chk("rst_deq",      a_if.fe_queue_dequeue_o,  0);
        chk("rst_clr",      a_if.fe_queue_clr_o,      0);
        chk("rst_rollback", a_if.fe_queue_rollback_o, 0);
        chk("rst_cmd_v",    a_if.fe_cmd_v_o,          0);
        chk("rst_cmd",      a_if.fe_cmd_o,            0);
        chk("rst_cnt",      a_cnt,                    0);
        chk("rst_done",     a_done,                   0);
        chk("rst_err",      a_err,                    0);
        @(negedge clk);
        rst_n = 1'b1;

        // Done at max_instr without any redirect
        yc = 0; dc = 0; cc = 0;
        for (int i = 0; i < 16; i++) begin
            apply_b(1'b1, 39'h80000124 + 39'(4 * i));
            if (b_if.fe_queue_yumi_o === 1'b1)    yc++;
            if (b_if.fe_queue_dequeue_o === 1'b1) dc++;
            if (b_if.fe_cmd_v_o === 1'b1)         cc++;
        end
        apply_b(1'b1, 39'h80000164);
        if (b_if.fe_cmd_v_o === 1'b1) cc++;
        chk("done_yumi_pulses",  yc, 16);
        chk("done_deq_pulses",   dc, 16);
        chk("done_cmd_pulses",   cc, 0);
        chk("done_flag",         b_done, 1);
        chk("done_cnt",          b_cnt, 16);
        chk("done_err",          b_err, 0);
        chk("done_yumi_blocked", b_if.fe_queue_yumi_o, 0);
        b_if.fe_queue_v_i = 1'b0;

        for (int i = 0; i < 13; i++) begin
            apply_a(tbl[i].v, tbl[i].exc, tbl[i].pc, tbl[i].rdy);
            chk($sformatf("v%0d_yumi", i),  a_if.fe_queue_yumi_o,    tbl[i].e_yumi);
            chk($sformatf("v%0d_deq", i),   a_if.fe_queue_dequeue_o, tbl[i].e_deq);
            chk($sformatf("v%0d_clr", i),   a_if.fe_queue_clr_o,     tbl[i].e_clr);
            chk($sformatf("v%0d_cmd_v", i), a_if.fe_cmd_v_o,         tbl[i].e_cmdv);
            if (tbl[i].e_cmdv)
                chk($sformatf("v%0d_cmd", i), a_if.fe_cmd_o, mk_cmd(tbl[i].e_vaddr));
        end
        apply_a(0, 0, 39'h0, 1);
        chk("redir_cnt", a_cnt, 6);

        // Reset while a command is pending
        apply_a(1, 0, 39'h8000017c, 1);
        chk("pre_rst_deq0", a_if.fe_queue_dequeue_o, 1);
        apply_a(1, 0, 39'h80000180, 1);
        chk("pre_rst_deq1", a_if.fe_queue_dequeue_o, 1);
        apply_a(0, 0, 39'h0, 0);
        chk("pre_rst_cmd_v", a_if.fe_cmd_v_o, 0);
        chk("pre_rst_cnt",   a_cnt, 8);
        rst_n = 1'b0;
        a_if.fe_cmd_rdy_i = 1'b1;
        #1;
        chk("in_rst_cmd_v", a_if.fe_cmd_v_o, 0);
        chk("in_rst_cnt",   a_cnt, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        apply_a(0, 0, 39'h0, 1);
        chk("post_rst_cmd_v", a_if.fe_cmd_v_o, 0);
        apply_a(1, 0, 39'h80000124, 1);
        chk("post_rst_deq",   a_if.fe_queue_dequeue_o, 1);
        apply_a(0, 0, 39'h0, 1);
        chk("post_rst_cnt",   a_cnt, 1);
        chk("post_rst_cmd_v2", a_if.fe_cmd_v_o, 0);

`ifdef BP_FE_MOCK_BE_CHECK_EN
        for (int k = 0; k < 8; k++) begin
            apply_a(1, 0, 39'h00dead00 + 39'(4 * k), 1);
            chk($sformatf("mm%0d_yumi", k), a_if.fe_queue_yumi_o,    1);
            chk($sformatf("mm%0d_deq", k),  a_if.fe_queue_dequeue_o, 0);
            chk($sformatf("mm%0d_err", k),  a_err,                   0);
        end
        apply_a(1, 0, 39'h80000128, 1);
        chk("mm_err",        a_err, 1);
        chk("mm_yumi_stuck", a_if.fe_queue_yumi_o, 0);
        chk("mm_cnt",        a_cnt, 1);
`else
        for (int k = 0; k < 2; k++) begin
            apply_a(1, 0, 39'h00dead00 + 39'(4 * k), 1);
            chk($sformatf("nochk%0d_deq", k), a_if.fe_queue_dequeue_o, 1);
        end
        apply_a(0, 0, 39'h0, 1);
        chk("nochk_cnt", a_cnt, 3);
        chk("nochk_err", a_err, 0);
`endif

        // Exception packet mid-stream
        a_if.fe_queue_v_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        apply_a(1, 0, 39'h80000124, 1);
        chk("exc_pre_deq",  a_if.fe_queue_dequeue_o, 1);
        apply_a(1, 1, 39'h80000128, 1);
        chk("exc_yumi",     a_if.fe_queue_yumi_o,    1);
        chk("exc_deq",      a_if.fe_queue_dequeue_o, 0);
        chk("exc_err_pre",  a_err,                   0);
        apply_a(1, 0, 39'h80000128, 1);
        chk("exc_err",      a_err,                   1);
        chk("exc_yumi_off", a_if.fe_queue_yumi_o,    0);
        chk("exc_cnt",      a_cnt,                   1);
        apply_a(0, 0, 39'h0, 1);
        chk("exc_err_hold", a_err,  1);
        chk("exc_done",     a_done, 0);
        chk("exc_cnt_hold", a_cnt,  1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
